// File: rtl/ahb_pkg.sv
// Shared AHB-Lite protocol codes (transfer type, size, response) used by
// masters and slaves alike, plus the byte-lane decode for sub-word writes.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'b000,
        HSIZE_HALF = 3'b001,
        HSIZE_WORD = 3'b010
    } hsize_e;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

    // Little-endian lane enables; only called for transfers already known aligned.
    function automatic logic [3:0] byte_lanes(input logic [1:0] offset, input logic [2:0] size);
        logic [3:0] lanes;
        case (size)
            HSIZE_BYTE: lanes = 4'b0001 << offset;
            HSIZE_HALF: lanes = offset[1] ? 4'b1100 : 4'b0011;
            default:    lanes = 4'b1111;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/ahb_slave_mem_if.sv
// AHB-Lite slave port bundle: address/data-phase inputs plus the slave
// response signals, viewed from either side through modports.
interface ahb_slave_mem_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  hsel;
    logic [31:0]           haddr;
    logic [1:0]            htrans;
    logic                  hwrite;
    logic [2:0]            hsize;
    logic [2:0]            hburst;
    logic [DATA_WIDTH-1:0] hwdata;
    logic                  hready;
    logic                  hreadyout;
    logic                  hresp;
    logic [DATA_WIDTH-1:0] hrdata;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
        input  hreadyout, hresp, hrdata
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
        output hreadyout, hresp, hrdata
    );
endinterface

// File: rtl/ahb_slave_ram.sv
// Single-port word RAM with per-byte write enables and asynchronous read.
// Contents are deliberately not reset.
module ahb_slave_ram #(
    parameter int MEM_DEPTH = 64,
    parameter int AW        = 6
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite memory slave: pipelined address/data phases, programmable OKAY
// wait states, two-cycle ERROR response, byte-lane writes into a local RAM.
module ahb_slave_mem
    import ahb_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic           hclk,
    input  logic           hrst_n,
    ahb_slave_mem_if.slave bus
);

    localparam int         AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [2:0] WAIT_LAST = 3'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_e;

    state_e      state, state_nxt;
    logic [2:0]  wait_cnt, wait_cnt_nxt;

    logic          vld_p0;
    logic          wr_p0;
    logic [2:0]    size_p0;
    logic [AW+1:0] addr_p0;

    logic        hreadyout_int;
    logic        accept, accept_err, accept_ok;
    logic [3:0]  ram_we;
    logic [31:0] ram_rdata;
    logic        unused_hburst;

    function automatic logic addr_err(input logic [31:0] a, input logic [2:0] sz);
        logic bad;
        bad = (a[31:2] >= 30'(MEM_DEPTH))
            || (sz > HSIZE_WORD)
            || ((sz == HSIZE_HALF) && a[0])
            || ((sz == HSIZE_WORD) && (a[1:0] != 2'b00));
        return bad;
    endfunction

    // Address phase decode: a transfer is only taken while our own data phase
    // is not stretching the bus.
    always_comb begin
        hreadyout_int = (state != WAIT) && (state != ERR1);
        accept        = bus.hsel && bus.hready && hreadyout_int
                     && ((bus.htrans == HTRANS_NONSEQ) || (bus.htrans == HTRANS_SEQ));
        accept_err    = accept && addr_err(bus.haddr, bus.hsize);
        accept_ok     = accept && !accept_err;
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            IDLE, ERR2: begin
                if (accept_err) begin
                    state_nxt = ERR1;
                end else if (accept_ok && (WAIT_STATES > 0)) begin
                    state_nxt    = WAIT;
                    wait_cnt_nxt = 3'd0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    wait_cnt_nxt = wait_cnt + 3'd1;
                end
            end
            ERR1:    state_nxt = ERR2;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge hclk or negedge hrst_n) begin
        if (!hrst_n) begin
            state    <= IDLE;
            wait_cnt <= 3'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Data phase _p0: captured address-phase controls; vld_p0 marks an OKAY
    // transfer in flight and drops on the edge that completes it.
    always_ff @(posedge hclk or negedge hrst_n) begin
        if (!hrst_n) begin
            vld_p0  <= 1'b0;
            wr_p0   <= 1'b0;
            size_p0 <= 3'd0;
            addr_p0 <= '0;
        end else begin
            if (hreadyout_int) begin
                vld_p0 <= accept_ok;
            end
            if (accept) begin
                wr_p0   <= bus.hwrite;
                size_p0 <= bus.hsize;
                addr_p0 <= bus.haddr[AW+1:0];
            end
        end
    end

    assign ram_we = (vld_p0 && wr_p0 && hreadyout_int) ? byte_lanes(addr_p0[1:0], size_p0) : 4'b0000;

    ahb_slave_ram #(
        .MEM_DEPTH (MEM_DEPTH),
        .AW        (AW)
    ) u_ram (
        .clk   (hclk),
        .we    (ram_we),
        .addr  (addr_p0[AW+1:2]),
        .wdata (bus.hwdata[31:0]),
        .rdata (ram_rdata)
    );

    assign bus.hreadyout = hreadyout_int;
    assign bus.hresp     = ((state == ERR1) || (state == ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign bus.hrdata    = (vld_p0 && !wr_p0) ? DATA_WIDTH'(ram_rdata) : '0;

    assign unused_hburst = ^bus.hburst;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench for ahb_slave_mem: three instances (0, 2 and 3 wait states) behind one
// pipelined master, checked cycle by cycle against a byte-level memory model.
module tb_ahb_slave_mem;
    import ahb_pkg::*;

    localparam int NDUT  = 3;
    localparam int DEPTH = 64;

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] wd;
    } xfer_t;

    logic hclk = 1'b0;
    logic hrst_n = 1'b0;
    always #5 hclk = ~hclk;

    logic        m_hsel;
    logic [31:0] m_haddr;
    logic [1:0]  m_htrans;
    logic        m_hwrite;
    logic [2:0]  m_hsize;
    logic [2:0]  m_hburst;
    logic [31:0] m_hwdata;
    logic        m_hready;
    int          sel_dut;

    logic        obs_rdy;
    logic        obs_resp;
    logic [31:0] obs_rdata;

    int          ncmp;
    int          nfail;
    logic [31:0] last_rdata;
    int          last_waits;
    logic [31:0] mdl [NDUT][DEPTH];
    xfer_t       q[$];

    ahb_slave_mem_if bus0();
    ahb_slave_mem_if bus1();
    ahb_slave_mem_if bus2();

    ahb_slave_mem #(.DATA_WIDTH(32), .MEM_DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (.hclk(hclk), .hrst_n(hrst_n), .bus(bus0));
    ahb_slave_mem #(.DATA_WIDTH(32), .MEM_DEPTH(DEPTH), .WAIT_STATES(2)) dut1 (.hclk(hclk), .hrst_n(hrst_n), .bus(bus1));
    ahb_slave_mem #(.DATA_WIDTH(32), .MEM_DEPTH(DEPTH), .WAIT_STATES(3)) dut2 (.hclk(hclk), .hrst_n(hrst_n), .bus(bus2));

    assign bus0.hsel = m_hsel && (sel_dut == 0);
    assign bus1.hsel = m_hsel && (sel_dut == 1);
    assign bus2.hsel = m_hsel && (sel_dut == 2);
    assign {bus0.haddr, bus1.haddr, bus2.haddr}    = {3{m_haddr}};
    assign {bus0.htrans, bus1.htrans, bus2.htrans} = {3{m_htrans}};
    assign {bus0.hwrite, bus1.hwrite, bus2.hwrite} = {3{m_hwrite}};
    assign {bus0.hsize, bus1.hsize, bus2.hsize}    = {3{m_hsize}};
    assign {bus0.hburst, bus1.hburst, bus2.hburst} = {3{m_hburst}};
    assign {bus0.hwdata, bus1.hwdata, bus2.hwdata} = {3{m_hwdata}};
    assign {bus0.hready, bus1.hready, bus2.hready} = {3{m_hready}};
    assign m_hready = obs_rdy;

    always_comb begin
        obs_rdy   = bus0.hreadyout;
        obs_resp  = bus0.hresp;
        obs_rdata = bus0.hrdata;
        if (sel_dut == 1) begin
            obs_rdy = bus1.hreadyout; obs_resp = bus1.hresp; obs_rdata = bus1.hrdata;
        end else if (sel_dut == 2) begin
            obs_rdy = bus2.hreadyout; obs_resp = bus2.hresp; obs_rdata = bus2.hrdata;
        end
    end

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : (d == 1) ? 2 : 3;
    endfunction

    function automatic bit is_err(input logic [31:0] a, input logic [2:0] sz);
        return ((a / 4) >= 32'(DEPTH)) || (sz > 3'd2)
            || ((sz == 3'd1) && ((a % 2) != 0)) || ((sz == 3'd2) && ((a % 4) != 0));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_write(input int d, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
        int w, off, n;
        w   = int'(a / 4);
        off = int'(a % 4);
        n   = (sz == 3'd0) ? 1 : (sz == 3'd1) ? 2 : 4;
        for (int b = off; b < off + n; b++) mdl[d][w][8*b +: 8] = wd[8*b +: 8];
    endtask

    task automatic push(input logic sel, input logic [1:0] trans, input logic [31:0] a,
                        input logic wr, input logic [2:0] sz, input logic [31:0] wd);
        xfer_t x;
        x.sel = sel; x.trans = trans; x.addr = a; x.wr = wr; x.size = sz; x.wd = wd;
        q.push_back(x);
    endtask

    task automatic push_rand();
        int r, off;
        logic [2:0] sz;
        logic [31:0] a;
        logic [1:0] tr;
        r  = $urandom_range(0, 9);
        tr = (r < 8) ? ((r % 2 != 0) ? HTRANS_SEQ : HTRANS_NONSEQ) : ((r == 8) ? HTRANS_IDLE : HTRANS_BUSY);
        r  = $urandom_range(0, 15);
        sz = (r < 12) ? 3'(r % 3) : 3'(3 + r % 5);
        r  = $urandom_range(0, 15);
        off = $urandom_range(0, 3);
        if (r < 13 && sz == 3'd1) off = off & 2;
        if (r < 13 && sz == 3'd2) off = 0;
        if (r == 0)      a = 32'h100 + 32'($urandom_range(0, 255));
        else if (r == 1) a = $urandom;
        else             a = 32'($urandom_range(0, DEPTH - 1) * 4 + off);
        push($urandom_range(0, 9) != 0, tr, a, 1'($urandom_range(0, 1)), sz, $urandom);
    endtask

    task automatic drive_addr(input int i);
        if (i < q.size()) begin
            m_hsel = q[i].sel; m_htrans = q[i].trans; m_haddr = q[i].addr;
            m_hwrite = q[i].wr; m_hsize = q[i].size;
        end else begin
            m_hsel = 1'b0; m_htrans = HTRANS_IDLE; m_haddr = $urandom;
            m_hwrite = 1'b0; m_hsize = HSIZE_WORD;
        end
        m_hburst = 3'($urandom_range(0, 7));
    endtask

    // Issue the queued transfers back-to-back on the selected instance and
    // check every cycle of every data phase, then empty the queue.
    task automatic run_q();
        int cur, k, idx, cycles, ws, d, limit;
        bit rdy, fin;
        xfer_t c;
        d = sel_dut; ws = ws_of(d);
        cur = -1; k = 0; idx = 0; cycles = 0; fin = 0;
        limit = 8 * q.size() + 20;
        drive_addr(idx);
        while (!fin) begin
            @(negedge hclk);
            rdy = obs_rdy;
            if (cur < 0) begin
                check("idle_rdy", 32'(obs_rdy), 32'd1);
                check("idle_resp", 32'(obs_resp), 32'd0);
                check("idle_rdata", obs_rdata, 32'd0);
            end else begin
                c = q[cur];
                if (is_err(c.addr, c.size)) begin
                    check("err_rdy", 32'(obs_rdy), (k == 1) ? 32'd1 : 32'd0);
                    check("err_resp", 32'(obs_resp), 32'd1);
                    check("err_rdata", obs_rdata, 32'd0);
                end else begin
                    check("ok_rdy", 32'(obs_rdy), (k == ws) ? 32'd1 : 32'd0);
                    check("ok_resp", 32'(obs_resp), 32'd0);
                    check("ok_rdata", obs_rdata, c.wr ? 32'd0 : mdl[d][int'(c.addr / 4)]);
                    if (rdy && !c.wr) begin
                        last_rdata = obs_rdata;
                        last_waits = k;
                    end
                end
            end
            @(posedge hclk);
            #1;
            cycles++;
            if (rdy) begin
                if (cur >= 0 && q[cur].wr && !is_err(q[cur].addr, q[cur].size))
                    model_write(d, q[cur].addr, q[cur].size, q[cur].wd);
                if (idx < q.size() && q[idx].sel && q[idx].trans[1]) cur = idx;
                else cur = -1;
                if (idx < q.size()) idx++;
                k = 0;
                drive_addr(idx);
                if (cur < 0 && idx >= q.size()) fin = 1;
            end else begin
                k++;
            end
            if (cur >= 0) m_hwdata = (k == ws) ? q[cur].wd : ~q[cur].wd;
            else          m_hwdata = $urandom;
            if (!fin && cycles > limit) begin
                ncmp++; nfail++;
                $error("FAIL run_q_timeout: observed %0d cycles expected at most %0d", cycles, limit);
                fin = 1;
            end
        end
        q.delete();
    endtask

    initial begin
        logic [31:0] pre;
        ncmp = 0; nfail = 0; sel_dut = 0;
        last_rdata = '0; last_waits = 0;
        m_hwdata = '0;
        drive_addr(0);
        hrst_n = 1'b0;
        #3;
        check("rst_rdy0", 32'(bus0.hreadyout), 32'd1);
        check("rst_resp0", 32'(bus0.hresp), 32'd0);
        check("rst_rdata0", bus0.hrdata, 32'd0);
        check("rst_rdy1", 32'(bus1.hreadyout), 32'd1);
        check("rst_resp1", 32'(bus1.hresp), 32'd0);
        check("rst_rdata1", bus1.hrdata, 32'd0);
        check("rst_rdy2", 32'(bus2.hreadyout), 32'd1);
        check("rst_resp2", 32'(bus2.hresp), 32'd0);
        check("rst_rdata2", bus2.hrdata, 32'd0);
        repeat (2) @(posedge hclk);
        #1 hrst_n = 1'b1;
        @(posedge hclk);
        #1;

        for (int d = 0; d < NDUT; d++) begin
            sel_dut = d;
            for (int w = 0; w < DEPTH; w++) push(1'b1, HTRANS_NONSEQ, 32'(w * 4), 1'b1, HSIZE_WORD, $urandom);
            run_q();
        end

        sel_dut = 0;
        push(1'b1, HTRANS_NONSEQ, 32'h10, 1'b1, HSIZE_WORD, 32'hDEAD_BEEF);
        push(1'b1, HTRANS_NONSEQ, 32'h10, 1'b0, HSIZE_WORD, 32'h0);
        run_q();
        check("b2b_rdata", last_rdata, 32'hDEAD_BEEF);
        check("b2b_waits", 32'(last_waits), 32'd0);

        sel_dut = 1;
        push(1'b1, HTRANS_NONSEQ, 32'h04, 1'b0, HSIZE_WORD, 32'h0);
        push(1'b1, HTRANS_SEQ, 32'h0C, 1'b1, HSIZE_WORD, $urandom);
        run_q();
        check("ws2_waits", 32'(last_waits), 32'd2);
        check("ws2_rdata", last_rdata, mdl[1][1]);

        for (int d = 0; d < NDUT; d += 2) begin
            sel_dut = d;
            push(1'b1, HTRANS_NONSEQ, 32'h0, 1'b1, HSIZE_WORD, 32'h1122_3344);
            push(1'b1, HTRANS_NONSEQ, 32'h2, 1'b1, HSIZE_BYTE, 32'h99AA_7788);
            push(1'b1, HTRANS_NONSEQ, 32'h0, 1'b1, HSIZE_HALF, 32'hCCDD_5566);
            push(1'b1, HTRANS_NONSEQ, 32'h0, 1'b0, HSIZE_WORD, 32'h0);
            run_q();
            check("lanes_rdata", last_rdata, 32'h11AA_5566);
        end

        for (int d = 0; d < NDUT; d++) begin
            sel_dut = d;
            pre = mdl[d][0];
            push(1'b1, HTRANS_NONSEQ, 32'h100, 1'b1, HSIZE_WORD, $urandom);
            push(1'b1, HTRANS_NONSEQ, 32'h1, 1'b1, HSIZE_HALF, $urandom);
            push(1'b1, HTRANS_NONSEQ, 32'h0, 1'b1, 3'b011, $urandom);
            push(1'b1, HTRANS_SEQ, 32'h2, 1'b1, HSIZE_WORD, $urandom);
            push(1'b1, HTRANS_NONSEQ, 32'h100, 1'b0, HSIZE_WORD, 32'h0);
            push(1'b1, HTRANS_NONSEQ, 32'h4, 1'b0, HSIZE_WORD, 32'h0);
            push(1'b1, HTRANS_NONSEQ, 32'h0, 1'b0, HSIZE_WORD, 32'h0);
            run_q();
            check("err_unchanged", last_rdata, pre);
        end

        sel_dut = 1;
        pre = mdl[1][2];
        push(1'b1, HTRANS_IDLE, 32'h8, 1'b1, HSIZE_WORD, ~pre);
        push(1'b1, HTRANS_BUSY, 32'h8, 1'b1, HSIZE_WORD, ~pre);
        push(1'b0, HTRANS_NONSEQ, 32'h8, 1'b1, HSIZE_WORD, ~pre);
        push(1'b1, HTRANS_NONSEQ, 32'h8, 1'b0, HSIZE_WORD, 32'h0);
        run_q();
        check("notrans_unchanged", last_rdata, pre);

        for (int d = 0; d < NDUT; d++) begin
            sel_dut = d;
            for (int n = 0; n < 120; n++) push_rand();
            push(1'b1, HTRANS_NONSEQ, 32'h0, 1'b0, HSIZE_WORD, 32'h0);
            run_q();
        end

        sel_dut = 2;
        push(1'b1, HTRANS_NONSEQ, 32'h20, 1'b1, HSIZE_WORD, 32'hCAFE_F00D);
        run_q();
        m_hsel = 1'b1; m_htrans = HTRANS_NONSEQ; m_haddr = 32'h20;
        m_hwrite = 1'b1; m_hsize = HSIZE_WORD;
        @(posedge hclk);
        #1;
        m_htrans = HTRANS_IDLE; m_hwdata = 32'h1234_5678;
        @(posedge hclk);
        #1;
        check("rst_mid_wait_rdy", 32'(obs_rdy), 32'd0);
        #2 hrst_n = 1'b0;
        #1;
        check("rst_mid_rdy", 32'(bus2.hreadyout), 32'd1);
        check("rst_mid_resp", 32'(bus2.hresp), 32'd0);
        check("rst_mid_rdata", bus2.hrdata, 32'd0);
        @(posedge hclk);
        #1 hrst_n = 1'b1;
        @(posedge hclk);
        #1;
        push(1'b1, HTRANS_NONSEQ, 32'h20, 1'b0, HSIZE_WORD, 32'h0);
        run_q();
        check("rst_word_kept", last_rdata, 32'hCAFE_F00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/ahb_slave_mem.md
AHB_SLAVE_MEM -- requirements
Module: ahb_slave_mem

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus width (only 32 supported).
REQ-002 SHALL have parameter MEM_DEPTH, default 64, number of 32-bit words.
REQ-003 SHALL have parameter WAIT_STATES, default 0, wait cycles (0..7) inserted per OKAY data phase.
REQ-004 SHALL have one clock and an asynchronous active-low reset: hclk  in  1  rising-edge clock; hrst_n  in  1  async reset, active low.
REQ-005 SHALL have ports: hsel  in  1  slave select; haddr  in  32  byte address; htrans  in  2  transfer type; hwrite  in  1  1=write; hsize  in  3  transfer size; hburst  in  3  burst type (ignored); hwdata  in  DATA_WIDTH  write data; hready  in  1  bus ready.
REQ-006 SHALL have outputs: hreadyout  out  1  slave ready; hresp  out  1  0=OKAY, 1=ERROR; hrdata  out  DATA_WIDTH  read data.

Function
REQ-007 SHALL accept a transfer at a rising edge when hsel=1, hready=1 and htrans is NONSEQ (2'b10) or SEQ (2'b11); it SHALL register haddr, hwrite and hsize at that edge.
REQ-008 SHALL treat IDLE/BUSY, or hsel=0, as no transfer: next cycle hreadyout=1 and hresp=0, with no memory access.
REQ-009 SHALL flag an accepted transfer as error if word index haddr[31:2] >= MEM_DEPTH, hsize > 3'b010, halfword with haddr[0]=1, or word with haddr[1:0]!=0.
REQ-010 SHALL use FSM states IDLE, WAIT, ERR1, ERR2; IDLE->WAIT on OKAY accept when WAIT_STATES>0, IDLE->ERR1 on error accept, WAIT->IDLE after WAIT_STATES cycles, ERR1->ERR2->IDLE unconditionally.
REQ-011 SHALL drive hreadyout=0, hresp=0 in WAIT; hreadyout=0, hresp=1 in ERR1; hreadyout=1, hresp=1 in ERR2.
REQ-012 SHALL complete an OKAY data phase in the cycle hreadyout=1: latency 1+WAIT_STATES cycles after the accept edge.
REQ-013 SHALL commit a write at the edge ending the OKAY data phase, sampling hwdata then, enabling little-endian byte lanes: BYTE lane haddr[1:0]; HALFWORD lanes {1,0} or {3,2} by haddr[1]; WORD all lanes.
REQ-014 SHALL drive hrdata combinationally with the full addressed word throughout an OKAY read data phase, and 0 otherwise.
REQ-015 SHALL never write memory for an error transfer, nor for a transfer whose data phase is cut short by reset.
REQ-016 SHALL accept a new address phase on the same edge that completes the previous data phase (pipelined back-to-back), including the ERR2 edge.
REQ-017 SHALL return data written by the immediately preceding transfer on a back-to-back read of the same address.
REQ-018 SHALL ignore hburst; bursts are handled as a sequence of single transfers.

Reset
REQ-019 SHALL on hrst_n=0 immediately force state IDLE, hreadyout=1, hresp=0, hrdata=0, and clear captured address-phase registers.
REQ-020 SHALL leave memory contents unreset; reads before any write return undefined data.

Structure
REQ-021 SHALL take HTRANS codes (IDLE, BUSY, NONSEQ, SEQ), HSIZE codes (BYTE, HALFWORD, WORD) and HRESP codes from shared package ahb_pkg, shared with the AHB master.
REQ-022 SHALL instantiate one sub-module ahb_slave_ram: MEM_DEPTH x 32 single-port, 4 byte-write enables, asynchronous read.

Verification
REQ-023 WAIT_STATES=0: write WORD 0x0000_0010 = 0xDEAD_BEEF, then back-to-back read of 0x10 -> hreadyout=1 in both data phases, hrdata=0xDEADBEEF, hresp=0.
REQ-024 WAIT_STATES=2: read of 0x04 -> hreadyout low exactly 2 cycles, then high with valid hrdata; next address held by master is accepted only on the completing edge.
REQ-025 Byte lanes: WORD write 0x0 = 0x11223344, BYTE write 0x2 = 0xAA, HALFWORD write 0x0 = 0x5566 (on lanes 1:0) -> WORD read 0x0 returns 0x11AA5566.
REQ-026 Errors: access to 0x100 (index 64), HALFWORD at 0x1, hsize=3'b011 -> each gives ERR1 (hreadyout=0, hresp=1) then ERR2 (1,1); memory unchanged on read-back.
REQ-027 IDLE/BUSY with hsel=1, and NONSEQ with hsel=0 -> hreadyout=1, hresp=0, no write.
REQ-028 Reset asserted during a WAIT_STATES=3 write data phase -> outputs return to reset values immediately; target word unchanged after reset release.
